// File: rtl/codec_cfg_target.sv
// Write-only I2C target for the audio-codec configuration bus. Accepts
// 16-bit register writes (7-bit register address, 9-bit data) and keeps
// them in a small register file with combinational readback.
module codec_cfg_target #(
    parameter logic [6:0]  DEV_ADDR  = 7'h1A,
    parameter int unsigned NUM_REGS  = 16,
    parameter int unsigned RESET_REG = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       wr_strobe,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    output logic       busy,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data
);

    typedef enum logic [2:0] {
        StIdle, StAddr, StAckA, StByte1, StAck1, StByte2, StAck2, StIgnore
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] shift_q, shift_d;
    logic       done_q, done_d;     // full byte sitting in shift_q
    logic       oe_q, oe_d;
    logic       busy_q, busy_d;
    logic [6:0] raddr_q, raddr_d;
    logic       d8_q, d8_d;
    logic       wr_strobe_q, wr_strobe_d;
    logic [6:0] wr_addr_q, wr_addr_d;
    logic [8:0] wr_data_q, wr_data_d;
    logic [8:0] regs_q [NUM_REGS];

    logic scl_s1, scl_s2, scl_h;
    logic sda_s1, sda_s2, sda_h;
    logic scl_rise, scl_fall, start_det, stop_det, shifting;

    // Two-flop synchronizers plus a history flop for edge detection; left
    // unreset so a reset never fabricates a bus edge.
    always_ff @(posedge clk) begin
        scl_s1 <= scl;
        scl_s2 <= scl_s1;
        scl_h  <= scl_s2;
        sda_s1 <= sda_in;
        sda_s2 <= sda_s1;
        sda_h  <= sda_s2;
    end

    assign scl_rise  = scl_s2 & ~scl_h;
    assign scl_fall  = ~scl_s2 & scl_h;
    assign start_det = scl_s2 & scl_h & sda_h & ~sda_s2;
    assign stop_det  = scl_s2 & scl_h & ~sda_h & sda_s2;
    assign shifting  = (state_q == StAddr) || (state_q == StByte1) || (state_q == StByte2);

    // Protocol state and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            done_q      <= 1'b0;
            oe_q        <= 1'b0;
            busy_q      <= 1'b0;
            raddr_q     <= '0;
            d8_q        <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            done_q      <= done_d;
            oe_q        <= oe_d;
            busy_q      <= busy_d;
            raddr_q     <= raddr_d;
            d8_q        <= d8_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // Next-state: bit shifting, byte decisions, ACK window and commit.
    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        done_d      = 1'b0;
        oe_d        = oe_q;
        busy_d      = busy_q;
        raddr_d     = raddr_q;
        d8_d        = d8_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;

        if (start_det) begin
            state_d  = StAddr;
            bitcnt_d = '0;
            oe_d     = 1'b0;
        end else if (stop_det) begin
            state_d = StIdle;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            if (shifting && scl_rise) begin
                shift_d  = {shift_q[6:0], sda_s2};
                bitcnt_d = bitcnt_q + 3'd1;
                done_d   = (bitcnt_q == 3'd7);
            end
            case (state_q)
                StAddr: begin
                    if (done_q) begin
                        if (shift_q[7:1] == DEV_ADDR && !shift_q[0]) begin
                            state_d = StAckA;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = StIgnore;
                            busy_d  = 1'b0;
                        end
                    end
                end
                StByte1: begin
                    if (done_q) begin
                        if (32'(shift_q[7:1]) < NUM_REGS) begin
                            raddr_d = shift_q[7:1];
                            d8_d    = shift_q[0];
                            state_d = StAck1;
                        end else begin
                            state_d = StIgnore;
                        end
                    end
                end
                StByte2: begin
                    if (done_q) begin
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = raddr_q;
                        wr_data_d   = {d8_q, shift_q};
                        state_d     = StAck2;
                    end
                end
                StAckA, StAck1, StAck2: begin
                    // First fall ends the 8th bit (drive), second ends the ACK bit.
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else begin
                            oe_d     = 1'b0;
                            bitcnt_d = '0;
                            case (state_q)
                                StAckA:  state_d = StByte1;
                                StAck1:  state_d = StByte2;
                                default: state_d = StIgnore;
                            endcase
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Register file: updated the cycle after the strobe; RESET_REG clears all.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rst) begin
                regs_q[i] <= '0;
            end else if (wr_strobe_q) begin
                if (32'(wr_addr_q) == RESET_REG) begin
                    regs_q[i] <= '0;
                end else if (32'(wr_addr_q) == i) begin
                    regs_q[i] <= wr_data_q;
                end
            end
        end
    end

    // Combinational readback; out-of-range selects read zero.
    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (32'(rd_addr) == i) begin
                rd_data = regs_q[i];
            end
        end
    end

    assign sda_oe    = oe_q;
    assign busy      = busy_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_codec_cfg_target.sv
// Directed bench for codec_cfg_target: the bench acts as I2C controller.
module tb_codec_cfg_target;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       sda_m;
    logic       sda_in;
    logic       sda_oe;
    logic       wr_strobe;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    logic       busy;
    logic [3:0] rd_addr;
    logic [8:0] rd_data;

    int tests = 0;
    int fails = 0;
    int stb_cnt = 0;
    int stb_wide = 0;
    int oe_rises = 0;
    logic stb_prev = 1'b0;
    logic oe_prev = 1'b0;

    // Open-drain bus: the line is low if either side pulls it.
    assign sda_in = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    codec_cfg_target dut (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl),
        .sda_in    (sda_in),
        .sda_oe    (sda_oe),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    // Strobe and ACK-drive event counters.
    always @(posedge clk) begin
        stb_prev <= wr_strobe;
        oe_prev  <= sda_oe;
        if (wr_strobe) stb_cnt <= stb_cnt + 1;
        if (wr_strobe && stb_prev) stb_wide <= stb_wide + 1;
        if (sda_oe && !oe_prev) oe_rises <= oe_rises + 1;
    end

    typedef struct {
        logic [7:0] b0, b1, b2;
        logic       a0, a1, a2;
        int         stb;
        logic [6:0] wa;
        logic [8:0] wd;
        logic [3:0] ra;
        logic [8:0] rd;
        logic       bsy;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; #100;
        scl   = 1'b1; #100;
        sda_m = 1'b0; #100;
        scl   = 1'b0; #100;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #100;
        scl   = 1'b1; #100;
        sda_m = 1'b1; #100;
    endtask

    // One byte MSB first plus the ACK slot; optional in-line latency checks.
    task automatic send_byte(input logic [7:0] b, input bit chk_oe, input bit chk_stb,
                             output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; #100;
            scl = 1'b1;
            if (chk_stb && i == 0) begin
                repeat (3) @(posedge clk);
                #1 check("stb_latency_early", 16'(wr_strobe), 16'd0);
                @(posedge clk);
                #1 check("stb_latency", 16'(wr_strobe), 16'd1);
                #164;
            end else begin
                #200;
            end
            scl = 1'b0;
            if (chk_oe && i == 0) begin
                repeat (2) @(posedge clk);
                #1 check("oe_latency_early", 16'(sda_oe), 16'd0);
                @(posedge clk);
                #1 check("oe_latency", 16'(sda_oe), 16'd1);
                #74;
            end else begin
                #100;
            end
        end
        sda_m = 1'b1; #100;
        scl = 1'b1; #100;
        ack = ~sda_in; #100;
        scl = 1'b0; #100;
    endtask

    task automatic do_write(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic ack;
        i2c_start();
        send_byte(b0, 1'b0, 1'b0, ack);
        send_byte(b1, 1'b0, 1'b0, ack);
        send_byte(b2, 1'b0, 1'b0, ack);
        i2c_stop();
    endtask

    initial begin
        logic ack0, ack1, ack2;
        int   s0, o0;

        tbl[0] = '{8'h34, 8'h0E, 8'h13, 1, 1, 1, 1, 7'h07, 9'h013, 4'd7, 9'h013, 1};
        tbl[1] = '{8'h34, 8'h09, 8'hFF, 1, 1, 1, 1, 7'h04, 9'h1FF, 4'd4, 9'h1FF, 1};
        tbl[2] = '{8'h36, 8'h0E, 8'h13, 0, 0, 0, 0, 7'h04, 9'h1FF, 4'd7, 9'h013, 0};
        tbl[3] = '{8'h35, 8'h0E, 8'h13, 0, 0, 0, 0, 7'h04, 9'h1FF, 4'd7, 9'h013, 0};
        tbl[4] = '{8'h34, 8'h20, 8'h55, 1, 0, 0, 0, 7'h04, 9'h1FF, 4'd4, 9'h1FF, 1};
        tbl[5] = '{8'h34, 8'h03, 8'hAA, 1, 1, 1, 1, 7'h01, 9'h1AA, 4'd1, 9'h1AA, 1};
        tbl[6] = '{8'h34, 8'h1E, 8'h00, 1, 1, 1, 1, 7'h0F, 9'h000, 4'd4, 9'h000, 1};

        rst = 1'b1; scl = 1'b1; sda_m = 1'b1; rd_addr = 4'd0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        check("rst_sda_oe", 16'(sda_oe), 16'd0);
        check("rst_wr_strobe", 16'(wr_strobe), 16'd0);
        check("rst_wr_addr", 16'(wr_addr), 16'd0);
        check("rst_wr_data", 16'(wr_data), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        rd_addr = 4'd7; #1;
        check("rst_rd_data", 16'(rd_data), 16'd0);
        #9;

        for (int v = 0; v < 7; v++) begin
            s0 = stb_cnt;
            o0 = oe_rises;
            i2c_start();
            send_byte(tbl[v].b0, 1'b0, 1'b0, ack0);
            send_byte(tbl[v].b1, 1'b0, 1'b0, ack1);
            send_byte(tbl[v].b2, 1'b0, 1'b0, ack2);
            check($sformatf("v%0d_busy", v), 16'(busy), 16'(tbl[v].bsy));
            i2c_stop();
            rd_addr = tbl[v].ra;
            #100;
            check($sformatf("v%0d_ack_addr", v), 16'(ack0), 16'(tbl[v].a0));
            check($sformatf("v%0d_ack_b1", v), 16'(ack1), 16'(tbl[v].a1));
            check($sformatf("v%0d_ack_b2", v), 16'(ack2), 16'(tbl[v].a2));
            check($sformatf("v%0d_oe_count", v), 16'(oe_rises - o0),
                  16'(32'(tbl[v].a0) + 32'(tbl[v].a1) + 32'(tbl[v].a2)));
            check($sformatf("v%0d_strobes", v), 16'(stb_cnt - s0), 16'(tbl[v].stb));
            check($sformatf("v%0d_wr_addr", v), 16'(wr_addr), 16'(tbl[v].wa));
            check($sformatf("v%0d_wr_data", v), 16'(wr_data), 16'(tbl[v].wd));
            check($sformatf("v%0d_rd_data", v), 16'(rd_data), 16'(tbl[v].rd));
            check($sformatf("v%0d_busy_after_stop", v), 16'(busy), 16'd0);
        end

        // After the RESET_REG write every register reads zero.
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a); #10;
            check($sformatf("clear_rd%0d", a), 16'(rd_data), 16'd0);
        end

        // Repeated START aborts the first write; only the second commits.
        do_write(8'h34, 8'h0E, 8'h13);
        s0 = stb_cnt;
        i2c_start();
        send_byte(8'h34, 1'b0, 1'b0, ack0);
        send_byte(8'h0E, 1'b0, 1'b0, ack1);
        check("rs_ack_addr", 16'(ack0), 16'd1);
        check("rs_ack_b1", 16'(ack1), 16'd1);
        i2c_start();
        send_byte(8'h34, 1'b0, 1'b0, ack0);
        send_byte(8'h02, 1'b0, 1'b0, ack1);
        send_byte(8'h17, 1'b0, 1'b0, ack2);
        i2c_stop();
        #100;
        check("rs_ack2", 16'(ack2), 16'd1);
        check("rs_strobes", 16'(stb_cnt - s0), 16'd1);
        check("rs_wr_addr", 16'(wr_addr), 16'd1);
        check("rs_wr_data", 16'(wr_data), 16'h017);
        rd_addr = 4'd7; #10;
        check("rs_reg7_kept", 16'(rd_data), 16'h013);
        rd_addr = 4'd1; #10;
        check("rs_reg1", 16'(rd_data), 16'h017);

        // Pin-to-output latency of the ACK drive and the write strobe.
        i2c_start();
        send_byte(8'h34, 1'b1, 1'b0, ack0);
        send_byte(8'h0A, 1'b0, 1'b0, ack1);
        send_byte(8'h5A, 1'b0, 1'b1, ack2);
        i2c_stop();
        rd_addr = 4'd5; #100;
        check("lat_rd5", 16'(rd_data), 16'h05A);

        // Reset in the middle of BYTE2: no commit, SDA released, later write works.
        s0 = stb_cnt;
        i2c_start();
        send_byte(8'h34, 1'b0, 1'b0, ack0);
        send_byte(8'h0C, 1'b0, 1'b0, ack1);
        for (int i = 7; i >= 4; i--) begin
            sda_m = 1'b1; #100;
            scl = 1'b1; #200;
            scl = 1'b0; #100;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("midrst_sda_oe", 16'(sda_oe), 16'd0);
        check("midrst_busy", 16'(busy), 16'd0);
        send_byte(8'h21, 1'b0, 1'b0, ack2);
        i2c_stop();
        rd_addr = 4'd6; #100;
        check("midrst_ack", 16'(ack2), 16'd0);
        check("midrst_strobes", 16'(stb_cnt - s0), 16'd0);
        check("midrst_rd6", 16'(rd_data), 16'd0);
        do_write(8'h34, 8'h0C, 8'h21);
        #100;
        check("post_rst_strobes", 16'(stb_cnt - s0), 16'd1);
        check("post_rst_wr_addr", 16'(wr_addr), 16'd6);
        check("post_rst_rd6", 16'(rd_data), 16'h021);

        check("strobe_width", 16'(stb_wide), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
